count_strobe_gen: RTL and testbench
===================================

# count_strobe_gen

Downstream consumer of the free-running `divider` counter. It selects one bit ("tap") of the incoming `count` bus and emits a single-cycle `strobe` on each rising edge of that tap. It also keeps a running tally of strobes and drives a toggling `blink` output. The block turns the raw divider value into a usable enable/tick for slower logic and board-level indicators.

## Interface
Parameters:
- `CNT_W`, 32: width of the `count` input.
- `TAP_W`, 5: width of `tap_sel`; must satisfy 2^TAP_W >= CNT_W.
- `EVT_W`, 16: width of `evt_count`.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `count`  in  CNT_W  free-running value from `divider`, updated once per `clk`.
- `en`  in  1  run enable; low forces IDLE.
- `tap_sel`  in  TAP_W  index of the tap bit; values >= CNT_W select bit CNT_W-1.
- `strobe`  out  1  one-cycle pulse per tap rising edge.
- `blink`  out  1  toggles on every `strobe`.
- `evt_count`  out  EVT_W  number of strobes since reset.
- `busy`  out  1  high when state is not IDLE.

## Operation
- FSM states: IDLE, ARM, RUN.
  - `rst` -> IDLE.
  - IDLE & `en` -> ARM.
  - ARM & `en` -> RUN. ARM & !`en` -> IDLE.
  - RUN & !`en` -> IDLE.
  - RUN & `en` & (`tap_sel` != `sel_q`) -> ARM.
- `sel_q` is the registered `tap_sel`. It updates every cycle.
- `tap_q` is the registered `count[sel]`, where `sel` is `tap_sel` after clamping. It is sampled every cycle in every state.
- ARM exists to reload `tap_q` from the new tap. No strobe is issued while in ARM, which prevents a spurious edge when the tap changes.
- Edge condition: state==RUN & `count[sel]`==1 & `tap_q`==0 & `tap_sel`==`sel_q`.
- On an edge:
  - `strobe` goes high the next cycle.
  - `blink` flips.
  - `evt_count` increments by 1.
- `evt_count` behaviour is set at compile time (see Configuration). It is never cleared by `en`; only `rst` clears it.
- A falling edge of the tap, or a tap that is held constant, produces nothing.
- `en` deasserting in the same cycle as an edge: the edge is honoured (strobe next cycle), then the FSM goes to IDLE.

## Timing
- Reset values: state IDLE, `strobe`=0, `blink`=0, `evt_count`=0, `busy`=0, `tap_q`=0, `sel_q`=0.
- `en` rising at cycle t: ARM at t+1, RUN at t+2. The first possible strobe is at t+3.
- Latency from the input cycle that shows the tap 0->1 to `strobe` high is 1 cycle.
- `strobe` is always exactly 1 cycle wide. A tap at bit 0 that toggles every cycle gives a strobe every 2nd cycle.
- Strobe period is 2^(k+1) cycles for tap k, given that `count` increments by 1 per cycle.
- The divider wrap (all-ones -> 0) is a falling edge on every bit and produces no strobe.
- A `tap_sel` change costs exactly 1 ARM cycle. Any edge in that cycle is lost.
- `rst` mid-operation: all outputs return to reset values on the next edge, whatever the state.

## Configuration
- `COUNT_STROBE_SAT_EN`:
  - Defined: `evt_count` saturates at 2^EVT_W-1 and holds.
  - Undefined: `evt_count` wraps modulo 2^EVT_W (all-ones + 1 -> 0).
  - `strobe` and `blink` are unaffected either way.

## Structure
- `count_strobe_pkg` holds:
  - the state enum (IDLE=0, ARM=1, RUN=2; 2-bit encoding);
  - the default width constants `CNT_W_DEF`, `TAP_W_DEF`, `EVT_W_DEF`.
- Sub-module `tap_edge_det`: the tap mux plus clamp, the `tap_q` register, and the rising-edge compare. Its output is a raw edge flag that the top-level FSM qualifies.
- The top level contains the FSM, the `sel_q` register, the output registers and the event counter.

## Test plan
- Reset: hold `rst`=1 for 10 cycles with `count` incrementing -> all outputs 0 and `busy`=0 throughout.
- `en`=1, `tap_sel`=0, `count` incrementing from 0 -> first strobe 3 cycles after `en`, then every 2 cycles. After 20 strobes, `evt_count`=20 and `blink`=0.
- `tap_sel`=3 -> strobes exactly 16 cycles apart. Change to `tap_sel`=1 mid-run -> one ARM cycle, no glitch strobe, then a 4-cycle period.
- `tap_sel`=31 with `count` preset to 0x7FFFFFFE, then 0xFFFFFFFF, then wrap to 0 -> exactly one strobe (at the 0x80000000 crossing), none at the wrap.
- `EVT_W`=4, tap 0, 20 strobes:
  - without the macro -> `evt_count`=4;
  - with `COUNT_STROBE_SAT_EN` -> `evt_count`=15.
- Drop `en` in the edge cycle, then assert `rst` mid-RUN -> one final strobe, then IDLE. After reset, all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/count_strobe_pkg.sv
// count_strobe_pkg: shared types and default widths for count_strobe_gen.
package count_strobe_pkg;

   localparam int CNT_W_DEF = 32;
   localparam int TAP_W_DEF = 5;
   localparam int EVT_W_DEF = 16;

   // ARM sits between IDLE and RUN so the tap register can reload before
   // edges are allowed to fire.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

endpackage

// File: rtl/tap_edge_det.sv
// tap_edge_det: selects one bit of the divider count (clamped to the top
// bit when tap_sel is out of range), registers it every cycle, and flags a
// raw 0->1 transition. The raw flag is qualified by the caller.
module tap_edge_det
   import count_strobe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TAP_W = TAP_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count,
   input  logic [TAP_W-1:0] tap_sel,
   output logic             edge_raw
);

   logic [TAP_W-1:0] sel;
   logic             tap_bit;
   logic             tap_q;

   // Clamp out-of-range selects onto the most significant count bit.
   always_comb begin
      sel = tap_sel;
      if (int'(tap_sel) >= CNT_W) begin
         sel = TAP_W'(CNT_W - 1);
      end
   end

   // Tap mux written as a compare loop so any CNT_W/TAP_W pairing stays legal.
   always_comb begin
      tap_bit = 1'b0;
      for (int i = 0; i < CNT_W; i++) begin
         if (sel == TAP_W'(i)) begin
            tap_bit = count[i];
         end
      end
   end

   // Previous tap value, sampled every cycle regardless of FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_q <= 1'b0;
      end else begin
         tap_q <= tap_bit;
      end
   end

   assign edge_raw = tap_bit & ~tap_q;

endmodule

// File: rtl/count_strobe_gen.sv
// count_strobe_gen: turns a free-running divider count into a one-cycle
// strobe on each rising edge of a selectable tap bit, with a blink toggle
// and a strobe tally. Build option COUNT_STROBE_SAT_EN makes the tally
// saturate instead of wrapping.
module count_strobe_gen
   import count_strobe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TAP_W = TAP_W_DEF,
   parameter int EVT_W = EVT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count,
   input  logic             en,
   input  logic [TAP_W-1:0] tap_sel,
   output logic             strobe,
   output logic             blink,
   output logic [EVT_W-1:0] evt_count,
   output logic             busy
);

   state_t           state;
   logic [TAP_W-1:0] sel_q;
   logic             edge_raw;
   logic             sel_same;
   logic             fire;

   tap_edge_det #(
      .CNT_W (CNT_W),
      .TAP_W (TAP_W)
   ) u_tap (
      .clk      (clk),
      .rst      (rst),
      .count    (count),
      .tap_sel  (tap_sel),
      .edge_raw (edge_raw)
   );

   // A changed select means tap_q holds a bit from the old tap, so the edge
   // compare is meaningless this cycle.
   assign sel_same = (tap_sel == sel_q);
   assign fire     = (state == RUN) & edge_raw & sel_same;

   // Registered copy of the raw select, used to detect tap changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= '0;
      end else begin
         sel_q <= tap_sel;
      end
   end

   // Run-control FSM; busy is registered alongside the state it mirrors.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               if (en) begin
                  state <= RUN;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               if (!en) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (!sel_same) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Strobe, blink and tally all follow the qualified edge by one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe    <= 1'b0;
         blink     <= 1'b0;
         evt_count <= '0;
      end else begin
         strobe <= fire;
         if (fire) begin
            blink <= ~blink;
`ifdef COUNT_STROBE_SAT_EN
            if (evt_count != {EVT_W{1'b1}}) begin
               evt_count <= evt_count + EVT_W'(1);
            end
`else
            evt_count <= evt_count + EVT_W'(1);
`endif
         end
      end
   end

endmodule

// File: tb/tb_count_strobe_gen.sv
// tb_count_strobe_gen: randomized and directed checks of count_strobe_gen
// against a per-cycle behavioural model. Two instances run on the same
// inputs: default widths, and a narrow one (CNT_W=20, EVT_W=4) that
// exercises tap clamping and the tally wrap/saturate option.
module tb_count_strobe_gen;

   localparam int CW  = 32;
   localparam int TW  = 5;
   localparam int EW  = 16;
   localparam int CW2 = 20;
   localparam int EW2 = 4;
`ifdef COUNT_STROBE_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [TW-1:0] tap_sel;
   logic [CW-1:0] count;
   logic          strobe, blink, busy;
   logic [EW-1:0] evt_count;
   logic          strobe2, blink2, busy2;
   logic [EW2-1:0] evt_count2;

   int nchk  = 0;
   int nfail = 0;
   int ncyc  = 0;

   // model state per instance: mode 0 idle, 1 arming, 2 running
   int m_mode[2];
   bit m_tap[2];
   int m_sel[2];
   bit m_strobe[2];
   bit m_blink[2];
   int m_evt[2];

   always #5 clk = ~clk;

   count_strobe_gen #(.CNT_W(CW), .TAP_W(TW), .EVT_W(EW)) u0 (
      .clk(clk), .rst(rst), .count(count), .en(en), .tap_sel(tap_sel),
      .strobe(strobe), .blink(blink), .evt_count(evt_count), .busy(busy)
   );

   count_strobe_gen #(.CNT_W(CW2), .TAP_W(TW), .EVT_W(EW2)) u1 (
      .clk(clk), .rst(rst), .count(count[CW2-1:0]), .en(en), .tap_sel(tap_sel),
      .strobe(strobe2), .blink(blink2), .evt_count(evt_count2), .busy(busy2)
   );

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int k, cw, emax;
      bit b, fire;
      for (int i = 0; i < 2; i++) begin
         cw   = (i == 0) ? CW : CW2;
         emax = (1 << ((i == 0) ? EW : EW2)) - 1;
         if (rst) begin
            m_mode[i] = 0; m_tap[i] = 0; m_sel[i] = 0;
            m_strobe[i] = 0; m_blink[i] = 0; m_evt[i] = 0;
         end else begin
            k    = (int'(tap_sel) >= cw) ? cw - 1 : int'(tap_sel);
            b    = count[k];
            fire = (m_mode[i] == 2) && b && !m_tap[i] && (int'(tap_sel) == m_sel[i]);
            m_strobe[i] = fire;
            if (fire) begin
               m_blink[i] = !m_blink[i];
               if (SAT) m_evt[i] = (m_evt[i] < emax) ? m_evt[i] + 1 : emax;
               else     m_evt[i] = (m_evt[i] + 1) % (emax + 1);
            end
            if (!en)                  m_mode[i] = 0;
            else if (m_mode[i] == 0)  m_mode[i] = 1;
            else if (m_mode[i] == 1)  m_mode[i] = 2;
            else if (int'(tap_sel) != m_sel[i]) m_mode[i] = 1;
            m_tap[i] = b;
            m_sel[i] = int'(tap_sel);
         end
      end
   endtask

   // One clock: model update, edge, settle, then the divider advances.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      count = count + 1;
      ncyc++;
   endtask

   task automatic test_reset();
      rst = 1; en = 1; tap_sel = 0; count = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         nchk++;
         if ({strobe, blink, busy, evt_count} !== '0) begin
            nfail++;
            $display("FAIL reset_out cyc %0d got s%b b%b busy%b evt%0d want all 0", ncyc, strobe, blink, busy, evt_count);
         end
         nchk++;
         if ({strobe2, blink2, busy2, evt_count2} !== '0) begin
            nfail++;
            $display("FAIL reset_out2 cyc %0d got s%b b%b busy%b evt%0d want all 0", ncyc, strobe2, blink2, busy2, evt_count2);
         end
      end
      rst = 0; en = 0;
   endtask

   task automatic test_tap0();
      int ns = 0, last = 0, c = 0;
      count = 1; tap_sel = 0; en = 1;
      while (ns < 20 && c < 200) begin
         cycle(); c++;
         if (strobe) begin
            if (ns == 0) begin
               nchk++;
               if (c !== 3) begin
                  nfail++; $display("FAIL tap0_first got cycle %0d want 3", c);
               end
            end else begin
               nchk++;
               if (c - last !== 2) begin
                  nfail++; $display("FAIL tap0_gap got %0d want 2", c - last);
               end
            end
            last = c; ns++;
         end
      end
      nchk++;
      if (ns !== 20) begin nfail++; $display("FAIL tap0_timeout got %0d strobes want 20", ns); end
      nchk++;
      if (evt_count !== 20) begin nfail++; $display("FAIL tap0_evt got %0d want 20", evt_count); end
      nchk++;
      if (blink !== 1'b0) begin nfail++; $display("FAIL tap0_blink got %b want 0", blink); end
      nchk++;
      if (evt_count2 !== (SAT ? 4'd15 : 4'd4)) begin
         nfail++; $display("FAIL evtw4 got %0d want %0d", evt_count2, SAT ? 15 : 4);
      end
   endtask

   task automatic test_tap_change();
      int ns = 0, last = 0;
      tap_sel = 3;
      for (int c = 1; c <= 150; c++) begin
         cycle();
         nchk++;
         if (strobe !== m_strobe[0]) begin
            nfail++; $display("FAIL tap3_strobe cyc %0d got %b want %b", ncyc, strobe, m_strobe[0]);
         end
         if (strobe) begin
            if (ns > 0) begin
               nchk++;
               if (c - last !== 16) begin nfail++; $display("FAIL tap3_gap got %0d want 16", c - last); end
            end
            last = c; ns++;
         end
      end
      nchk++;
      if (ns < 8) begin nfail++; $display("FAIL tap3_count got %0d want >=8", ns); end
      tap_sel = 1; ns = 0;
      cycle();
      nchk++;
      if (strobe !== 1'b0 || busy !== 1'b1) begin
         nfail++; $display("FAIL tap_change_arm got s%b busy%b want s0 busy1", strobe, busy);
      end
      for (int c = 1; c <= 40; c++) begin
         cycle();
         nchk++;
         if (strobe !== m_strobe[0]) begin
            nfail++; $display("FAIL tap1_strobe cyc %0d got %b want %b", ncyc, strobe, m_strobe[0]);
         end
         if (strobe) begin
            if (ns > 0) begin
               nchk++;
               if (c - last !== 4) begin nfail++; $display("FAIL tap1_gap got %0d want 4", c - last); end
            end
            last = c; ns++;
         end
      end
   endtask

   task automatic test_wrap();
      int ns = 0;
      tap_sel = 31; count = 32'h7FFF_FFFC;
      for (int c = 0; c < 16; c++) begin
         if (c == 8) count = 32'hFFFF_FFFD;
         cycle();
         nchk++;
         if (strobe !== m_strobe[0]) begin
            nfail++; $display("FAIL wrap_strobe cyc %0d got %b want %b", ncyc, strobe, m_strobe[0]);
         end
         nchk++;
         if (strobe2 !== m_strobe[1]) begin
            nfail++; $display("FAIL clamp_strobe cyc %0d got %b want %b", ncyc, strobe2, m_strobe[1]);
         end
         if (strobe) ns++;
      end
      nchk++;
      if (ns !== 1) begin nfail++; $display("FAIL wrap_count got %0d want 1", ns); end
   endtask

   task automatic test_en_drop();
      int c = 0;
      tap_sel = 0; en = 1;
      while (!(m_mode[0] == 2 && count[0] && !m_tap[0] && m_sel[0] == 0) && c < 20) begin
         cycle(); c++;
      end
      nchk++;
      if (c >= 20) begin nfail++; $display("FAIL en_drop_timeout got %0d cycles want <20", c); end
      en = 0;
      cycle();
      nchk++;
      if (strobe !== 1'b1 || busy !== 1'b0) begin
         nfail++; $display("FAIL en_drop_edge got s%b busy%b want s1 busy0", strobe, busy);
      end
      cycle();
      nchk++;
      if (strobe !== 1'b0 || busy !== 1'b0) begin
         nfail++; $display("FAIL en_drop_after got s%b busy%b want s0 busy0", strobe, busy);
      end
      en = 1;
      repeat (5) cycle();
      nchk++;
      if (busy !== 1'b1) begin nfail++; $display("FAIL rerun_busy got %b want 1", busy); end
      rst = 1;
      cycle();
      nchk++;
      if ({strobe, blink, busy, evt_count} !== '0) begin
         nfail++; $display("FAIL mid_reset got s%b b%b busy%b evt%0d want all 0", strobe, blink, busy, evt_count);
      end
      rst = 0; en = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom % 300) == 0;
         en  = ($urandom % 20) != 0;
         if (($urandom % 40) == 0)
            tap_sel = ($urandom % 2) ? TW'($urandom_range(0, 4)) : TW'($urandom_range(0, 31));
         if (($urandom % 80) == 0) count = $urandom;
         cycle();
         nchk++;
         if (strobe !== m_strobe[0] || blink !== m_blink[0]) begin
            nfail++; $display("FAIL rnd_sb0 cyc %0d got s%b b%b want s%b b%b", ncyc, strobe, blink, m_strobe[0], m_blink[0]);
         end
         nchk++;
         if (busy !== (m_mode[0] != 0) || int'(evt_count) !== m_evt[0]) begin
            nfail++; $display("FAIL rnd_be0 cyc %0d got busy%b evt%0d want busy%b evt%0d", ncyc, busy, evt_count, m_mode[0] != 0, m_evt[0]);
         end
         nchk++;
         if (strobe2 !== m_strobe[1] || blink2 !== m_blink[1]) begin
            nfail++; $display("FAIL rnd_sb1 cyc %0d got s%b b%b want s%b b%b", ncyc, strobe2, blink2, m_strobe[1], m_blink[1]);
         end
         nchk++;
         if (busy2 !== (m_mode[1] != 0) || int'(evt_count2) !== m_evt[1]) begin
            nfail++; $display("FAIL rnd_be1 cyc %0d got busy%b evt%0d want busy%b evt%0d", ncyc, busy2, evt_count2, m_mode[1] != 0, m_evt[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_tap0();
      test_tap_change();
      test_wrap();
      test_en_drop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
